// File: rtl/conv2_calc_pkg.sv
// Shared constants, binary weights and thresholds for the conv2_calc binary convolution layer.
// Thresholds in THRESH are only used when CONV2_CALC_THRESH_EN is defined.
package conv2_calc_pkg;

  localparam int NUM_CH      = 8;
  localparam int KERNEL_TAPS = 9;
  localparam int WIN_W       = NUM_CH * KERNEL_TAPS;  // 72
  localparam int CNT_W       = 7;                     // holds 0..72
  localparam int CH_CNT_W    = 4;                     // holds 0..9
  localparam int MAX_FILTERS = 16;

  localparam logic [CNT_W-1:0] DEFAULT_THRESH = 7'd36;

  localparam logic [CNT_W-1:0] THRESH [MAX_FILTERS] = '{
    7'd36, 7'd40, 7'd30, 7'd60, 7'd45, 7'd20, 7'd50, 7'd36,
    7'd38, 7'd33, 7'd70, 7'd10, 7'd72, 7'd0,  7'd55, 7'd41
  };

  // Filter weights are a fixed hash of the filter index, so any NUM_FILTERS gets a defined set.
  function automatic logic [WIN_W-1:0] weight(input int f);
    logic [31:0] h;
    h = (32'h9E37_79B9 * 32'(f + 1)) ^ 32'h5A5A_1234;
    return {h[7:0], ~h, h ^ 32'hA5C3_0F96};
  endfunction

  function automatic logic [CNT_W-1:0] thresh(input int f);
    return THRESH[f % MAX_FILTERS];
  endfunction

endpackage

// File: rtl/conv2_calc_popcnt9.sv
// Combinational popcount of one 3x3 binary kernel window (9 bits -> 0..9).
module popcnt9
  import conv2_calc_pkg::*;
(
  input  logic [KERNEL_TAPS-1:0] bits,
  output logic [CH_CNT_W-1:0]    count
);

  always_comb begin
    // NOTE: assigning the output a default before the loop keeps this purely combinational (no latch).
    count = '0;
    for (int i = 0; i < KERNEL_TAPS; i++) begin
      count += CH_CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/conv2_calc.sv
// Binary conv layer: XNOR-popcount of a 72-bit window against each filter, thresholded, 3-stage pipe.
// Define CONV2_CALC_THRESH_EN to use the per-filter thresholds; otherwise every filter uses 36.
module conv2_calc
  import conv2_calc_pkg::*;
#(
  parameter int NUM_FILTERS = 16,
  parameter int OUT_W       = 11,
  parameter int OUT_H       = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIN_W-1:0]       pixel_windows,
  input  logic                   valid_in,
  output logic [NUM_FILTERS-1:0] pixel_out,
  output logic                   valid_out,
  output logic                   frame_done
);

  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  logic [2:0]             vld;
  logic [NUM_FILTERS-1:0] pass;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       row;
  logic                   last_col;
  logic                   last_row;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every stage samples the previous stage's pre-edge value.
    if (!rst_n) vld <= '0;
    else        vld <= {vld[1:0], valid_in};
  end

  for (genvar f = 0; f < NUM_FILTERS; f++) begin : g_filt
    localparam logic [WIN_W-1:0] WGT = weight(f);
`ifdef CONV2_CALC_THRESH_EN
    localparam logic [CNT_W-1:0] TH = thresh(f);
`else
    localparam logic [CNT_W-1:0] TH = DEFAULT_THRESH;
`endif

    logic [WIN_W-1:0]           match;
    logic [NUM_CH*CH_CNT_W-1:0] ch_cnt;
    logic [NUM_CH*CH_CNT_W-1:0] s1_cnt;
    logic [CNT_W-1:0]           ch_total;
    logic [CNT_W-1:0]           s2_sum;

    assign match = ~(pixel_windows ^ WGT);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      popcnt9 u_popcnt (
        .bits  (match[c*KERNEL_TAPS +: KERNEL_TAPS]),
        .count (ch_cnt[c*CH_CNT_W +: CH_CNT_W])
      );
    end

    always_comb begin
      ch_total = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        ch_total += CNT_W'(s1_cnt[c*CH_CNT_W +: CH_CNT_W]);
      end
    end

    // Data stages run every cycle; the valid shift register qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: pipeline data registers are reset too, so a mid-frame reset leaves no stale values behind.
      if (!rst_n) begin
        s1_cnt <= '0;
        s2_sum <= '0;
      end else begin
        s1_cnt <= ch_cnt;
        s2_sum <= ch_total;
      end
    end

    assign pass[f] = (s2_sum >= TH);
  end

  assign last_col = (col == COL_W'(OUT_W - 1));
  assign last_row = (row == ROW_W'(OUT_H - 1));

  // col/row name the output position about to be written into pixel_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out  <= '0;
      frame_done <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      frame_done <= vld[1] && last_col && last_row;
      if (vld[1]) begin
        pixel_out <= pass;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign valid_out = vld[2];

endmodule

// File: tb/tb_conv2_calc.sv
// Self-checking bench for conv2_calc: directed steps plus random windows against a popcount model.
module tb_conv2_calc;
  import conv2_calc_pkg::*;

  localparam int NF    = 16;
  localparam int OW    = 11;
  localparam int OH    = 11;
  localparam int FRAME = OW * OH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [WIN_W-1:0] pixel_windows = '0;
  logic             valid_in = 1'b0;
  logic [NF-1:0]    pixel_out;
  logic             valid_out;
  logic             frame_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic             v;
    logic [WIN_W-1:0] win;
  } item_t;

  item_t         lat_q[$];
  logic [NF-1:0] exp_pix;
  int            out_cnt;
  int            fd_seen;

  conv2_calc #(.NUM_FILTERS(NF), .OUT_W(OW), .OUT_H(OH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_windows (pixel_windows),
    .valid_in      (valid_in),
    .pixel_out     (pixel_out),
    .valid_out     (valid_out),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int thr_of(input int f);
`ifdef CONV2_CALC_THRESH_EN
    return int'(thresh(f));
`else
    return 36;
`endif
  endfunction

  // Reference: each filter fires when its count of equal bits reaches its threshold.
  function automatic logic [NF-1:0] ref_out(input logic [WIN_W-1:0] win);
    logic [NF-1:0] r;
    for (int f = 0; f < NF; f++) begin
      r[f] = ($countones(~(win ^ weight(f))) >= thr_of(f));
    end
    return r;
  endfunction

  // Window that agrees with filter f's weights in exactly k bit positions.
  function automatic logic [WIN_W-1:0] win_k(input int f, input int k);
    logic [WIN_W-1:0] w;
    logic [WIN_W-1:0] r;
    w = weight(f);
    r = ~w;
    for (int i = 0; i < k; i++) r[i] = w[i];
    return r;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[WIN_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    item_t idle;
    idle.v   = 1'b0;
    idle.win = '0;
    lat_q.delete();
    lat_q.push_back(idle);
    lat_q.push_back(idle);
    exp_pix = '0;
    out_cnt = 0;
  endtask

  // One clock: drive, step past the edge, then compare against the 3-cycle-delayed model.
  task automatic cycle(input logic v, input logic [WIN_W-1:0] win);
    item_t it;
    item_t e;
    logic  exp_fd;
    valid_in      = v;
    pixel_windows = win;
    @(posedge clk);
    #1;
    it.v   = v;
    it.win = win;
    lat_q.push_back(it);
    e = lat_q.pop_front();
    exp_fd = 1'b0;
    if (e.v) begin
      exp_pix = ref_out(e.win);
      exp_fd  = ((out_cnt % FRAME) == FRAME - 1);
      out_cnt++;
    end
    check("valid_out", 64'(valid_out), 64'(e.v));
    check("frame_done", 64'(frame_done), 64'(exp_fd));
    check("pixel_out", 64'(pixel_out), 64'(exp_pix));
    if (frame_done) fd_seen++;
  endtask

  task automatic apply_reset();
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("rst_pixel_out", 64'(pixel_out), 64'd0);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1;
    apply_reset();

    // Exact weight match, then its complement.
    cycle(1'b1, weight(0));
    cycle(1'b0, '0);
    check("w0_valid", 64'(valid_out), 64'd0);
    cycle(1'b0, '0);
    check("w0_valid_lat3", 64'(valid_out), 64'd1);
    check("w0_bit0", 64'(pixel_out[0]), 64'd1);
    cycle(1'b1, ~weight(0));
    repeat (2) cycle(1'b0, '0);
    check("notw0_bit0", 64'(pixel_out[0]), 64'd0);

    // Threshold boundary on the configured threshold.
`ifdef CONV2_CALC_THRESH_EN
    cycle(1'b1, win_k(3, 59));
    repeat (2) cycle(1'b0, '0);
    check("t3_59", 64'(pixel_out[3]), 64'd0);
    cycle(1'b1, win_k(3, 60));
    repeat (2) cycle(1'b0, '0);
    check("t3_60", 64'(pixel_out[3]), 64'd1);
`else
    cycle(1'b1, win_k(0, 36));
    repeat (2) cycle(1'b0, '0);
    check("t0_36", 64'(pixel_out[0]), 64'd1);
    cycle(1'b1, win_k(0, 35));
    repeat (2) cycle(1'b0, '0);
    check("t0_35", 64'(pixel_out[0]), 64'd0);
`endif

    // Gap pattern 1,0,0,1,1 with pixel_out held in the gaps.
    cycle(1'b1, rand_win());
    cycle(1'b0, rand_win());
    cycle(1'b0, rand_win());
    cycle(1'b1, rand_win());
    cycle(1'b1, rand_win());
    repeat (3) cycle(1'b0, rand_win());

    // Two back-to-back frames.
    apply_reset();
    fd_seen = 0;
    repeat (2 * FRAME) cycle(1'b1, rand_win());
    repeat (3) cycle(1'b0, '0);
    check("two_frames_fd_count", 64'(fd_seen), 64'd2);

    // Mid-frame reset after 50 outputs with 2 windows in flight.
    apply_reset();
    repeat (52) cycle(1'b1, rand_win());
    apply_reset();
    fd_seen = 0;
    repeat (3) cycle(1'b0, rand_win());
    repeat (FRAME) cycle(1'b1, rand_win());
    repeat (3) cycle(1'b0, '0);
    check("post_reset_fd_count", 64'(fd_seen), 64'd1);

    // Random traffic with random gaps.
    repeat (300) cycle($urandom_range(0, 3) != 0, rand_win());
    repeat (3) cycle(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
